// File: rtl/dpram_be_init.sv
// Single-clock true dual-port RAM with byte enables and a post-reset clear sequencer.
// Define DPRAM_FWD_EN to forward same-cycle cross-port writes into reads; default is read-first.
module dpram_be_init #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 10,
  parameter bit                OUT_REG   = 1'b0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_din,
  input  logic                 a_we,
  input  logic [DATA_W/8-1:0]  a_be,
  input  logic                 a_rd,
  output logic [DATA_W-1:0]    a_dout,
  output logic                 a_rvalid,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_din,
  input  logic                 b_we,
  input  logic [DATA_W/8-1:0]  b_be,
  input  logic                 b_rd,
  output logic [DATA_W-1:0]    b_dout,
  output logic                 b_rvalid,
  output logic                 o_dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic                w_run;
  logic                w_port_en;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   w_mask_a, w_mask_b;
  logic [DATA_W-1:0]   w_merged_a, w_merged_b;
  logic                w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic [DATA_W-1:0]   w_rdat_a, w_rdat_b;
  logic [1:0][DATA_W-1:0] r_q1;
  logic [1:0]          r_v1;
  logic [1:0][DATA_W-1:0] w_dout;
  logic [1:0]          w_vout;

  // State register and clear counter; reset always restarts the clear from word 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == {ADDR_W{1'b1}}) w_next = ST_RUN;
      ST_RUN:   w_next = ST_RUN;
      default:  w_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy        = (r_state == ST_CLEAR);
    w_run       = (r_state == ST_RUN);
    o_dbg_state = r_state;
  end

  assign w_port_en = w_run && !reset;
  assign w_wr_a    = w_port_en && a_we;
  assign w_wr_b    = w_port_en && b_we;
  assign w_rd_a    = w_port_en && a_rd && !a_we;
  assign w_rd_b    = w_port_en && b_rd && !b_we;

  // Byte masks and merged words; A's merge starts from B's result so A wins shared bytes
  always_comb begin
    w_mask_a = '0;
    w_mask_b = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_mask_a[8*i +: 8] = {8{a_be[i]}};
      w_mask_b[8*i +: 8] = {8{b_be[i]}};
    end
    w_merged_b = (r_mem[b_addr] & ~w_mask_b) | (b_din & w_mask_b);
    w_merged_a = (((w_wr_b && (b_addr == a_addr)) ? w_merged_b : r_mem[a_addr]) & ~w_mask_a)
               | (a_din & w_mask_a);
  end

  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_CLEAR)) begin
      r_mem[r_cnt] <= CLEAR_VAL;
    end else begin
      if (w_wr_b) r_mem[b_addr] <= w_merged_b;
      if (w_wr_a) r_mem[a_addr] <= w_merged_a;
    end
  end

  always_comb begin
    w_rdat_a = r_mem[a_addr];
    w_rdat_b = r_mem[b_addr];
`ifdef DPRAM_FWD_EN
    if (w_wr_b && (b_addr == a_addr)) w_rdat_a = w_merged_b;
    if (w_wr_a && (a_addr == b_addr)) w_rdat_b = w_merged_a;
`endif
  end

  // Read stage 1: data only updates on an accepted read so dout holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q1 <= '0;
      r_v1 <= '0;
    end else begin
      r_v1 <= {w_rd_b, w_rd_a};
      if (w_rd_a) r_q1[0] <= w_rdat_a;
      if (w_rd_b) r_q1[1] <= w_rdat_b;
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [1:0][DATA_W-1:0] r_q2;
      logic [1:0]             r_v2;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_q2 <= '0;
          r_v2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1[0]) r_q2[0] <= r_q1[0];
          if (r_v1[1]) r_q2[1] <= r_q1[1];
        end
      end
      assign w_dout = r_q2;
      assign w_vout = r_v2;
    end else begin : g_noreg
      assign w_dout = r_q1;
      assign w_vout = r_v1;
    end
  endgenerate

  assign a_dout   = w_dout[0];
  assign b_dout   = w_dout[1];
  assign a_rvalid = w_vout[0];
  assign b_rvalid = w_vout[1];

endmodule
